// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel pushbutton debouncer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: width helper, logical level constants, parameter legality check.
package debounce_pkg;

  // Logical levels after polarity correction.
  localparam logic LVL_PRESSED  = 1'b1;
  localparam logic LVL_RELEASED = 1'b0;

  // $clog2 clamped so a counter that only ever holds 0 still gets one bit.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Elaboration-time sanity check of the debouncer parameter set.
  function automatic bit params_legal(input int div, input int num_ch,
                                      input int stable, input int sync);
    return (div >= 1) && (num_ch >= 1) && (stable >= 1) && (sync >= 2);
  endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debouncer channel: counts disagreeing samples, flips level, emits strobes.
// Latency: level changes on the STABLE_SAMPLES-th consecutive disagreeing tick.
// Backpressure: none; strobes are single-cycle and cannot be stalled.
//
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_sample       : synchronised, polarity-corrected button level
//   i_tick         : shared sample strobe
//   o_debbtn       : debounced level (1 = pressed)
//   o_press        : one-cycle strobe on 0->1 of o_debbtn
//   o_release      : one-cycle strobe on 1->0 of o_debbtn
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int STABLE_SAMPLES = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sample,
  input  logic i_tick,
  output logic o_debbtn,
  output logic o_press,
  output logic o_release
);

  localparam int CW = clog2_min1(STABLE_SAMPLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_SAMPLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt       <= '0;
      o_debbtn  <= LVL_RELEASED;
      o_press   <= 1'b0;
      o_release <= 1'b0;
    end else begin
      // Strobes default low; only the flipping edge raises one of them.
      o_press   <= 1'b0;
      o_release <= 1'b0;
      if (i_tick) begin
        if (i_sample == o_debbtn) begin
          // Any agreeing sample cancels a pending change (bounce rejection).
          cnt <= '0;
        end else if (cnt == CNT_LAST) begin
          cnt       <= '0;
          o_debbtn  <= i_sample;
          o_press   <= (i_sample == LVL_PRESSED);
          o_release <= (i_sample == LVL_RELEASED);
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/debounce_multi.sv
// Multi-channel pushbutton debouncer: polarity fix, synchroniser, prescaler, channels.
// Latency: worst case SYNC_STAGES + STABLE_SAMPLES*DIV cycles from input step to level.
// Backpressure: none; all outputs are free-running registered levels/strobes.
//
// Ports:
//   i_clk, i_rst_n : clock, async active-low reset
//   i_btn          : raw asynchronous button inputs, NUM_CH wide
//   o_debbtn       : debounced logical levels (1 = pressed)
//   o_press        : per-channel one-cycle press strobes
//   o_release      : per-channel one-cycle release strobes
//   o_tick         : shared sample strobe, high when the prescaler is at DIV-1
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CLOCK_RATE_HZ  = 16_000_000,
  parameter int SAMPLE_RATE_HZ = 1_000,
  parameter int NUM_CH         = 4,
  parameter int STABLE_SAMPLES = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int ACTIVE_LOW     = 0
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [NUM_CH-1:0] i_btn,
  output logic [NUM_CH-1:0] o_debbtn,
  output logic [NUM_CH-1:0] o_press,
  output logic [NUM_CH-1:0] o_release,
  output logic              o_tick
);

  localparam int DIV = CLOCK_RATE_HZ / SAMPLE_RATE_HZ;
  localparam int PW  = clog2_min1(DIV);
  localparam logic [PW-1:0] PCNT_LAST = PW'(DIV - 1);

  if (!params_legal(DIV, NUM_CH, STABLE_SAMPLES, SYNC_STAGES)) begin : g_bad_params
    $error("debounce_multi: illegal parameters (need DIV>=1, NUM_CH>=1, STABLE_SAMPLES>=1, SYNC_STAGES>=2)");
  end

  // Synchroniser holds logical (post-polarity) levels so reset = released.
  logic [NUM_CH-1:0] s_raw;
  logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
  logic [NUM_CH-1:0] s_sync;

  assign s_raw  = (ACTIVE_LOW != 0) ? ~i_btn : i_btn;
  assign s_sync = sync_q[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= s_raw;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  // Prescaler: tick is decoded from the count register, so DIV=1 ticks always.
  logic [PW-1:0] pcnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pcnt <= '0;
    end else if (pcnt == PCNT_LAST) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  assign o_tick = (pcnt == PCNT_LAST);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
    debounce_chan #(
      .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_chan (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_sample (s_sync[c]),
      .i_tick   (o_tick),
      .o_debbtn (o_debbtn[c]),
      .o_press  (o_press[c]),
      .o_release(o_release[c])
    );
  end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: vector table plus multi-cycle corner sequences.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_debounce_multi;

  logic i_clk;
  logic i_rst_n;

  // dut_a: DIV=1, STABLE=4, SYNC=2, active-high, 4 channels
  logic [3:0] btn_a, deb_a, press_a, rel_a;
  logic       tick_a;
  // dut_b: DIV=16, STABLE=4, 1 channel
  logic       btn_b, deb_b, press_b, rel_b, tick_b;
  // dut_c: DIV=1, STABLE=4, active-low, 4 channels
  logic [3:0] btn_c, deb_c, press_c, rel_c;
  logic       tick_c;

  debounce_multi #(
    .CLOCK_RATE_HZ(1), .SAMPLE_RATE_HZ(1), .NUM_CH(4),
    .STABLE_SAMPLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(0)
  ) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(btn_a),
    .o_debbtn(deb_a), .o_press(press_a), .o_release(rel_a), .o_tick(tick_a)
  );

  debounce_multi #(
    .CLOCK_RATE_HZ(16), .SAMPLE_RATE_HZ(1), .NUM_CH(1),
    .STABLE_SAMPLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(0)
  ) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(btn_b),
    .o_debbtn(deb_b), .o_press(press_b), .o_release(rel_b), .o_tick(tick_b)
  );

  debounce_multi #(
    .CLOCK_RATE_HZ(1), .SAMPLE_RATE_HZ(1), .NUM_CH(4),
    .STABLE_SAMPLES(4), .SYNC_STAGES(2), .ACTIVE_LOW(1)
  ) dut_c (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_btn(btn_c),
    .o_debbtn(deb_c), .o_press(press_c), .o_release(rel_c), .o_tick(tick_c)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] btn;
    logic [3:0] deb;
    logic [3:0] press;
    logic [3:0] rel;
  } vec_t;

  vec_t tbl[$];

  task automatic put(input logic [3:0] b, input logic [3:0] d,
                     input logic [3:0] p, input logic [3:0] r);
    vec_t v;
    v.btn = b; v.deb = d; v.press = p; v.rel = r;
    tbl.push_back(v);
  endtask

  // Hold reset two edges, release on a falling edge; next rising edge is edge 1.
  task automatic do_reset();
    i_rst_n = 1'b0;
    btn_a   = 4'h0;
    btn_b   = 1'b0;
    btn_c   = 4'hf;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  int npress, nrel;

  initial begin
    i_rst_n = 1'b0;
    btn_a   = 4'h0;
    btn_b   = 1'b0;
    btn_c   = 4'hf;

    // ---------------- reset state ----------------
    #1;
    chk("rst_deb_a",   deb_a,   4'h0);
    chk("rst_press_a", press_a, 4'h0);
    chk("rst_rel_a",   rel_a,   4'h0);
    chk("rst_deb_c",   deb_c,   4'h0);
    chk("rst_tick_b",  4'(tick_b), 4'h0);

    // ---------------- table: step, short pulse, release, multi-channel ----------------
    // row n = state after edge n+1 following reset release
    repeat (5) put(4'h1, 4'h0, 4'h0, 4'h0);   // ch0 step, sync + counting
    put(4'h1, 4'h1, 4'h1, 4'h0);              // edge 6: level rises, press
    repeat (2) put(4'h1, 4'h1, 4'h0, 4'h0);
    repeat (3) put(4'h3, 4'h1, 4'h0, 4'h0);   // ch1 3-cycle pulse: rejected
    repeat (5) put(4'h1, 4'h1, 4'h0, 4'h0);
    repeat (5) put(4'h0, 4'h1, 4'h0, 4'h0);   // ch0 release
    put(4'h0, 4'h0, 4'h0, 4'h1);
    put(4'h0, 4'h0, 4'h0, 4'h0);
    repeat (5) put(4'hc, 4'h0, 4'h0, 4'h0);   // ch2+ch3 together
    put(4'hc, 4'hc, 4'hc, 4'h0);
    put(4'hc, 4'hc, 4'h0, 4'h0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      btn_a = tbl[i].btn;
      @(posedge i_clk); #1;
      chk($sformatf("tbl%0d_deb", i),   deb_a,   tbl[i].deb);
      chk($sformatf("tbl%0d_press", i), press_a, tbl[i].press);
      chk($sformatf("tbl%0d_rel", i),   rel_a,   tbl[i].rel);
      chk($sformatf("tbl%0d_tick", i),  4'(tick_a), 4'h1);
    end

    // ---------------- reset mid-count and mid-strobe ----------------
    do_reset();
    btn_a = 4'h1;
    repeat (4) @(posedge i_clk); #1;           // counter now at 2
    i_rst_n = 1'b0; #1;
    chk("midcnt_deb", deb_a, 4'h0);
    @(negedge i_clk); i_rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge i_clk); #1;
      chk($sformatf("rst1_e%0d_deb", k),   deb_a,   (k == 6) ? 4'h1 : 4'h0);
      chk($sformatf("rst1_e%0d_press", k), press_a, (k == 6) ? 4'h1 : 4'h0);
    end
    i_rst_n = 1'b0; #1;                        // strobe is high right now
    chk("midstb_deb",   deb_a,   4'h0);
    chk("midstb_press", press_a, 4'h0);
    repeat (2) @(posedge i_clk); #1;
    chk("inrst_press", press_a, 4'h0);
    chk("inrst_rel",   rel_a,   4'h0);
    @(negedge i_clk); i_rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge i_clk); #1;
      chk($sformatf("rst2_e%0d_deb", k),   deb_a,   (k >= 6) ? 4'h1 : 4'h0);
      chk($sformatf("rst2_e%0d_press", k), press_a, (k == 6) ? 4'h1 : 4'h0);
      chk($sformatf("rst2_e%0d_rel", k),   rel_a,   4'h0);
    end

    // ---------------- ch2 alternating every 3 ticks, then held ----------------
    do_reset();
    for (int cyc = 0; cyc < 102; cyc++) begin
      btn_a[2] = (((cyc / 3) % 2) == 0);
      @(posedge i_clk); #1;
      chk($sformatf("alt%0d", cyc), {1'b0, deb_a[2], press_a[2], rel_a[2]}, 4'h0);
    end
    btn_a[2] = 1'b1;
    npress = 0;
    nrel   = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge i_clk); #1;
      if (press_a[2]) npress++;
      if (rel_a[2])   nrel++;
    end
    chk("hold_npress", 4'(npress), 4'h1);
    chk("hold_nrel",   4'(nrel),   4'h0);
    chk("hold_deb",    4'(deb_a[2]), 4'h1);

    // ---------------- DIV=16 tick cadence and general-case latency ----------------
    do_reset();
    chk("tick_b_rel", 4'(tick_b), 4'h0);
    btn_b = 1'b1;
    for (int k = 1; k <= 66; k++) begin
      @(posedge i_clk); #1;
      chk($sformatf("tick_b_e%0d", k), 4'(tick_b), 4'((k % 16) == 15));
      if (k == 63) chk("b_deb_e63", 4'(deb_b), 4'h0);
      if (k == 64) begin
        chk("b_deb_e64",   4'(deb_b),   4'h1);
        chk("b_press_e64", 4'(press_b), 4'h1);
        chk("b_rel_e64",   4'(rel_b),   4'h0);
      end
      if (k == 65) chk("b_press_e65", 4'(press_b), 4'h0);
    end

    // ---------------- active-low, several channels at once ----------------
    do_reset();
    btn_c = 4'b0101;
    for (int k = 1; k <= 7; k++) begin
      @(posedge i_clk); #1;
      chk($sformatf("c_e%0d_deb", k),   deb_c,   (k >= 6) ? 4'b1010 : 4'h0);
      chk($sformatf("c_e%0d_press", k), press_c, (k == 6) ? 4'b1010 : 4'h0);
      chk($sformatf("c_e%0d_rel", k),   rel_c,   4'h0);
      chk($sformatf("c_e%0d_tick", k),  4'(tick_c), 4'h1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel pushbutton debouncer for board-level inputs. Each raw input passes through a synchroniser and is sampled on a shared slow tick derived from the system clock. It drives its debounced level only after a programmable number of consecutive disagreeing samples. It also produces single-cycle press and release strobes, so downstream logic (counters, menu FSMs, UART triggers) needs no edge detector of its own.

## Interface
- CLOCK_RATE_HZ, 16_000_000, system clock frequency.
- SAMPLE_RATE_HZ, 1_000, sample tick rate. DIV = CLOCK_RATE_HZ/SAMPLE_RATE_HZ, integer division, must be ≥1 (elaboration error otherwise).
- NUM_CH, 4, number of independent channels (≥1).
- STABLE_SAMPLES, 8, consecutive disagreeing samples required to change output (≥1).
- SYNC_STAGES, 2, synchroniser depth (≥2).
- ACTIVE_LOW, 0, 1 = raw inputs are active-low and are inverted before synchronisation.
- i_clk  in  1  system clock; all state on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_btn  in  NUM_CH  raw asynchronous button inputs.
- o_debbtn  out  NUM_CH  debounced logical level (1 = pressed).
- o_press  out  NUM_CH  one-cycle strobe when o_debbtn[c] goes 0→1.
- o_release  out  NUM_CH  one-cycle strobe when o_debbtn[c] goes 1→0.
- o_tick  out  1  shared sample strobe, exported for test and for reuse by other slow logic.

## Operation
- Reset (i_rst_n=0, asynchronous): all outputs 0, prescaler count 0, all channel counters 0, all synchroniser flops at logical 0 (post-polarity). Release takes effect on the next rising edge.
- Polarity: s_raw[c] = i_btn[c] XOR ACTIVE_LOW, then passes through SYNC_STAGES flops to give s[c].
- Prescaler: pcnt counts 0..DIV-1, width max(1,$clog2(DIV)), wraps to 0 after DIV-1. o_tick = (pcnt == DIV-1), decoded from the register. DIV=1 gives o_tick constantly 1.
- Per channel, on an edge where o_tick=1:
  - s[c] == o_debbtn[c]: cnt[c] ← 0 (any agreeing sample cancels a pending change; bounces shorter than the threshold are rejected).
  - otherwise, if cnt[c] == STABLE_SAMPLES-1: o_debbtn[c] ← s[c], cnt[c] ← 0, and o_press[c] or o_release[c] ← 1 according to direction.
  - otherwise: cnt[c] ← cnt[c]+1. The counter never exceeds STABLE_SAMPLES-1, so it cannot overflow. Width max(1,$clog2(STABLE_SAMPLES)).
- On an edge with o_tick=0: cnt and o_debbtn hold.
- o_press and o_release are registered and forced to 0 on every edge that does not change o_debbtn. They are never both high on one channel.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own strobes in the same cycle.

## Timing
- With DIV=1: a clean step on i_btn[c], first captured at edge 1, changes o_debbtn[c] at edge SYNC_STAGES+STABLE_SAMPLES. The matching strobe is high for exactly the following cycle.
- General case: the change occurs at the STABLE_SAMPLES-th tick edge after the synchronised value changes. Worst-case latency is (SYNC_STAGES + STABLE_SAMPLES·DIV) cycles.
- After reset release, the first o_tick is high during the cycle in which pcnt=DIV-1, and the first channel update is on edge DIV.
- Reset asserted mid-count or mid-strobe clears everything immediately. No strobe is emitted as a consequence of reset.

## Structure
- Shared package debounce_pkg holds:
  - a clog2-with-minimum-1 width helper;
  - constants for the logical pressed/released levels;
  - the elaboration-time parameter legality checks.
- Sub-module debounce_chan holds one channel's counter, output and strobe logic. Its inputs are i_clk, i_rst_n, the synchronised sample and the tick. debounce_multi instantiates it NUM_CH times in a generate loop; the synchroniser and prescaler stay in the top module.

## Test plan
- DIV=1, STABLE_SAMPLES=4, SYNC_STAGES=2; step i_btn[0] 0→1 and hold → o_debbtn[0] rises at edge 6, o_press[0]=1 for one cycle, o_release stays 0.
- Same config; pulse i_btn[1] high for 3 cycles then low → o_debbtn[1], o_press[1] and o_release[1] remain 0 throughout.
- DIV=16; observe o_tick → first high in cycle 16 after reset release, then every 16 cycles, width 1 cycle.
- NUM_CH=4, ACTIVE_LOW=1; drive i_btn=4'b0101 from all-ones → o_debbtn=4'b1010 after threshold, o_press=4'b1010 in a single cycle.
- Reset asserted while cnt[0]=2 and again during an o_press strobe → all outputs 0 immediately; after release, a held input needs the full threshold again.
- Alternate i_btn[2] every 3 ticks for 100 ticks with STABLE_SAMPLES=4 → no output change. Then hold for 4 ticks → exactly one strobe.
